frame_diff_mem_sched: RTL

//  Schedules one shared burst-memory port between the current-frame write stream and the

---
 rtl/frame_diff_mem_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_diff_mem_sched.sv
// Burst-memory scheduler for the frame-difference write/read streams.
// Optional: FDIFF_URGENT_EN gives writes priority at high FIFO level.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   pre_img_vsync     frame start on rising edge
//   frame_gap_sel     0: ref = previous frame, 1: two frames back
//   wr_fifo_level     words waiting to be written
//   rd_fifo_free      free space in the read FIFO
//   mem_cmd_*         burst command (valid/ready, wr, addr, len)
//   mem_done          pulse when the accepted burst completes
//   wr_bank, rd_bank  current write / reference bank
//   prev_valid        reference frame present in memory
//   sched_busy        scheduler not idle
module frame_diff_mem_sched #(
    parameter int H_DISP      = 800,
    parameter int V_DISP      = 600,
    parameter int NUM_BANKS   = 3,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_W      = 24,
    parameter int BANK_STRIDE = 2**19,
    parameter int URG_LVL     = 448
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_img_vsync,
    input  logic              frame_gap_sel,
    input  logic [9:0]        wr_fifo_level,
    input  logic [9:0]        rd_fifo_free,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [7:0]        mem_cmd_len,
    input  logic              mem_done,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic              prev_valid,
    output logic              sched_busy
);

    localparam int FRAME_WORDS = H_DISP * V_DISP;
    localparam int OFF_W       = $clog2(FRAME_WORDS + 1);

    localparam logic [OFF_W-1:0]  FW     = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W-1:0]  BL     = OFF_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BANK_STRIDE);
    localparam logic [1:0]        LAST_B = 2'(NUM_BANKS - 1);
    localparam logic [9:0]        URG    = 10'(URG_LVL);

`ifdef FDIFF_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_CMD,
        S_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [OFF_W-1:0] wr_off, rd_off;
    logic [OFF_W-1:0] wr_rem, rd_rem;
    logic [7:0]       wr_len, rd_len;
    logic [1:0]       frames_done;
    logic             rr_last_wr;
    logic             vsync_q;
    logic             frame_pend;
    logic             wr_req, rd_req;
    logic             grant_wr;
    logic             do_rot, do_grant, do_accept;
    logic [1:0]       nxt_wr, nxt_rd;
    logic [2:0]       back;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign wr_rem = FW - wr_off;
    assign rd_rem = FW - rd_off;
    assign wr_len = (wr_rem >= BL) ? 8'(BURST_LEN) : 8'(wr_rem);
    assign rd_len = (rd_rem >= BL) ? 8'(BURST_LEN) : 8'(rd_rem);

    assign wr_req = (wr_off < FW)
                  && (wr_fifo_level >= {2'b00, wr_len});
    assign rd_req = prev_valid && (rd_off < FW)
                  && (rd_fifo_free >= {2'b00, rd_len});

    // Round-robin: the side not granted last wins a tie.
    always_comb begin
        grant_wr = wr_req && (!rd_req || !rr_last_wr);
        if (URG_EN && wr_req && (wr_fifo_level >= URG))
            grant_wr = 1'b1;
    end

    assign wr_addr = ADDR_W'(wr_bank) * STRIDE + ADDR_W'(wr_off);
    assign rd_addr = ADDR_W'(rd_bank) * STRIDE + ADDR_W'(rd_off);

    // Bank ring arithmetic for the rotation at frame start.
    always_comb begin
        nxt_wr = (wr_bank == LAST_B) ? 2'd0 : wr_bank + 2'd1;
        back   = 3'd1 + {2'b00, frame_gap_sel};
        if ({1'b0, nxt_wr} >= back)
            nxt_rd = 2'({1'b0, nxt_wr} - back);
        else
            nxt_rd = 2'({1'b0, nxt_wr} + 3'(NUM_BANKS) - back);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_rot    = 1'b0;
        do_grant  = 1'b0;
        do_accept = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_pend) begin
                    do_rot    = 1'b1;
                    state_nxt = S_ARB;
                end else if (wr_req || rd_req) begin
                    state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (wr_req || rd_req) begin
                    do_grant  = 1'b1;
                    state_nxt = S_CMD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    do_accept = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_cmd_valid = (state == S_CMD);
    assign sched_busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_pend  <= 1'b0;
            wr_bank     <= 2'd0;
            rd_bank     <= 2'd0;
            wr_off      <= '0;
            rd_off      <= '0;
            frames_done <= 2'd0;
            prev_valid  <= 1'b0;
            rr_last_wr  <= 1'b0;
            mem_cmd_wr  <= 1'b0;
            mem_cmd_addr <= '0;
            mem_cmd_len <= 8'd0;
        end else begin
            vsync_q <= pre_img_vsync;
            // A new edge in the rotation cycle is a new frame: keep it.
            if (pre_img_vsync && !vsync_q)
                frame_pend <= 1'b1;
            else if (do_rot)
                frame_pend <= 1'b0;

            if (do_rot) begin
                wr_bank <= nxt_wr;
                rd_bank <= nxt_rd;
                wr_off  <= '0;
                rd_off  <= '0;
                if (frames_done != 2'd3)
                    frames_done <= frames_done + 2'd1;
                // Pre-increment count: the frame written before the
                // first vsync is partial and never a valid reference.
                prev_valid <= (frames_done >= back[1:0]);
            end

            if (do_grant) begin
                rr_last_wr   <= grant_wr;
                mem_cmd_wr   <= grant_wr;
                mem_cmd_len  <= grant_wr ? wr_len : rd_len;
                mem_cmd_addr <= grant_wr ? wr_addr : rd_addr;
            end

            if (do_accept) begin
                if (mem_cmd_wr)
                    wr_off <= wr_off + OFF_W'(mem_cmd_len);
                else
                    rd_off <= rd_off + OFF_W'(mem_cmd_len);
            end
        end
    end

endmodule
